// File: rtl/reg_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module      : reg_scoreboard_if
// Description : Issue / writeback / status bundle for the register-hazard
//               scoreboard. The master side (decode) drives the issue
//               request, flush and the variable-latency writeback strobe.
//               The slave side (scoreboard) returns issue_ready, the busy
//               mask, the pending count, the stall counter and the sticky
//               spurious-writeback flag.
// Revision    : 1.0 - initial release
// ============================================================================
interface reg_scoreboard_if #(
    parameter int NREGS       = 32,
    parameter int STALL_CNT_W = 16
);
    logic                   issue_valid;
    logic [4:0]             issue_rs1;
    logic [4:0]             issue_rs2;
    logic                   issue_use_rs1;
    logic                   issue_use_rs2;
    logic [4:0]             issue_rd;
    logic                   issue_wr;
    logic                   issue_long;
    logic                   flush;
    logic                   wb_valid;
    logic [4:0]             wb_rd;
    logic                   issue_ready;
    logic [NREGS-1:0]       busy_mask;
    logic [5:0]             pending_cnt;
    logic [STALL_CNT_W-1:0] stall_cnt;
    logic                   err_spurious_wb;

    modport master (
        output issue_valid, issue_rs1, issue_rs2, issue_use_rs1, issue_use_rs2,
               issue_rd, issue_wr, issue_long, flush, wb_valid, wb_rd,
        input  issue_ready, busy_mask, pending_cnt, stall_cnt, err_spurious_wb
    );

    modport slave (
        input  issue_valid, issue_rs1, issue_rs2, issue_use_rs1, issue_use_rs2,
               issue_rd, issue_wr, issue_long, flush, wb_valid, wb_rd,
        output issue_ready, busy_mask, pending_cnt, stall_cnt, err_spurious_wb
    );
endinterface
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : reg_scoreboard
// Description : Decode-stage register-hazard scoreboard. Tracks in-flight
//               destination writes and holds off issue on RAW/WAW hazards.
//               Fixed-latency writes retire FIX_LAT cycles after issue;
//               variable-latency (LOAD) writes retire on a writeback strobe.
// Ports       : clk   - clock, all state updates on the rising edge
//               rst_n - synchronous active-low reset
//               sb    - reg_scoreboard_if.slave (issue request, flush,
//                       writeback strobe; issue_ready, busy_mask,
//                       pending_cnt, stall_cnt, err_spurious_wb)
// Options     : SCOREBOARD_WB_BYPASS_EN - when defined, a LONG entry being
//               written back this cycle and a FIX entry in its last busy
//               cycle are treated as free by the hazard check.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_scoreboard #(
    parameter int NREGS       = 32,
    parameter int FIX_LAT     = 2,
    parameter int STALL_CNT_W = 16
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    reg_scoreboard_if.slave  sb
);

    localparam logic [2:0] c_fix_lat = 3'(FIX_LAT);

    logic [NREGS-1:0]        r_busy;
    logic [NREGS-1:0]        r_long;
    logic [NREGS-1:0][2:0]   r_cnt;
    logic [5:0]              r_pending;
    logic [STALL_CNT_W-1:0]  r_stall;
    logic                    r_err;

    logic [NREGS-1:0]        w_hold;
    logic                    w_hazard;
    logic                    w_ready;
    logic                    w_set_en;
    logic                    w_spurious;
    logic [NREGS-1:0]        w_busy_nxt;
    logic [NREGS-1:0]        w_long_nxt;
    logic [NREGS-1:0][2:0]   w_cnt_nxt;
    logic [5:0]              w_pop;

    // Busy view used by the hazard check; with bypass, entries that are
    // retiring at this very edge no longer block a dependent.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            w_hold[i] = r_busy[i];
`ifdef SCOREBOARD_WB_BYPASS_EN
            if (r_long[i] && sb.wb_valid && (sb.wb_rd == 5'(i)))
                w_hold[i] = 1'b0;
            if (!r_long[i] && (r_cnt[i] == 3'd1))
                w_hold[i] = 1'b0;
`endif
        end
        w_hold[0] = 1'b0;
    end

    assign w_hazard = (sb.issue_use_rs1 && w_hold[sb.issue_rs1]) ||
                      (sb.issue_use_rs2 && w_hold[sb.issue_rs2]) ||
                      (sb.issue_wr      && w_hold[sb.issue_rd]);
    assign w_ready  = !w_hazard && !sb.flush;
    assign w_set_en = sb.issue_valid && w_ready && sb.issue_wr &&
                      (sb.issue_rd != 5'd0);

    // Anything other than a writeback to a busy LONG entry is spurious.
    assign w_spurious = sb.wb_valid &&
                        ((sb.wb_rd == 5'd0) || !r_busy[sb.wb_rd] ||
                         !r_long[sb.wb_rd]);

    // Next-state per register. The accept is applied last so that a new
    // entry overrides a same-cycle retirement of the old one.
    always_comb begin
        w_busy_nxt = r_busy;
        w_long_nxt = r_long;
        w_cnt_nxt  = r_cnt;
        for (int i = 0; i < NREGS; i++) begin
            if (r_busy[i] && !r_long[i]) begin
                w_cnt_nxt[i] = r_cnt[i] - 3'd1;
                if (r_cnt[i] == 3'd1)
                    w_busy_nxt[i] = 1'b0;
            end
            if (r_busy[i] && r_long[i] && sb.wb_valid &&
                (sb.wb_rd == 5'(i)))
                w_busy_nxt[i] = 1'b0;
            if (w_set_en && (sb.issue_rd == 5'(i))) begin
                w_busy_nxt[i] = 1'b1;
                w_long_nxt[i] = sb.issue_long;
                if (!sb.issue_long)
                    w_cnt_nxt[i] = c_fix_lat;
            end
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_comb begin
        w_pop = 6'd0;
        for (int i = 0; i < NREGS; i++)
            w_pop = w_pop + {5'd0, w_busy_nxt[i]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy    <= '0;
            r_long    <= '0;
            r_cnt     <= '0;
            r_pending <= '0;
            r_stall   <= '0;
            r_err     <= 1'b0;
        end else begin
            r_busy    <= w_busy_nxt;
            r_long    <= w_long_nxt;
            r_cnt     <= w_cnt_nxt;
            r_pending <= w_pop;
            if (sb.issue_valid && !w_ready && (r_stall != '1))
                r_stall <= r_stall + 1'b1;
            if (w_spurious)
                r_err <= 1'b1;
        end
    end

    assign sb.issue_ready     = w_ready;
    assign sb.busy_mask       = r_busy;
    assign sb.pending_cnt     = r_pending;
    assign sb.stall_cnt       = r_stall;
    assign sb.err_spurious_wb = r_err;

endmodule
`default_nettype wire

// File: tb/tb_reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_scoreboard
// Description : Self-checking bench for reg_scoreboard. A per-register
//               behavioural model (busy flag, LONG flag, remaining cycles)
//               predicts every output each cycle; directed scenarios add
//               literal expectations, followed by a randomized phase and a
//               stall-counter saturation run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_scoreboard;

    localparam int NREGS       = 32;
    localparam int FIX_LAT     = 2;
    localparam int STALL_CNT_W = 16;
    localparam int STALL_MAX   = (1 << STALL_CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n;

    reg_scoreboard_if #(.NREGS(NREGS), .STALL_CNT_W(STALL_CNT_W)) sbi ();

    reg_scoreboard #(
        .NREGS      (NREGS),
        .FIX_LAT    (FIX_LAT),
        .STALL_CNT_W(STALL_CNT_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .sb   (sbi)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state.
    bit m_busy [NREGS];
    bit m_long [NREGS];
    int m_rem  [NREGS];
    int m_stall;
    bit m_err;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
                     $time);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < NREGS; r++) begin
            m_busy[r] = 0;
            m_long[r] = 0;
            m_rem[r]  = 0;
        end
        m_stall = 0;
        m_err   = 0;
    endtask

    // A register blocks issue unless idle, x0, or (with bypass) retiring now.
    function automatic bit blocks(input int r);
        if (r == 0 || !m_busy[r]) return 0;
`ifdef SCOREBOARD_WB_BYPASS_EN
        if (m_long[r] && sbi.wb_valid && int'(sbi.wb_rd) == r) return 0;
        if (!m_long[r] && m_rem[r] == 1) return 0;
`endif
        return 1;
    endfunction

    function automatic bit model_ready();
        bit haz;
        haz = (sbi.issue_use_rs1 && blocks(int'(sbi.issue_rs1))) ||
              (sbi.issue_use_rs2 && blocks(int'(sbi.issue_rs2))) ||
              (sbi.issue_wr      && blocks(int'(sbi.issue_rd)));
        return !haz && !sbi.flush;
    endfunction

    task automatic model_update(input bit rdy);
        int w;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (sbi.issue_valid && !rdy)
            m_stall = (m_stall == STALL_MAX) ? STALL_MAX : m_stall + 1;
        w = int'(sbi.wb_rd);
        if (sbi.wb_valid) begin
            if (w == 0 || !m_busy[w] || !m_long[w]) m_err = 1;
            else m_busy[w] = 0;
        end
        for (int r = 1; r < NREGS; r++) begin
            if (m_busy[r] && !m_long[r]) begin
                m_rem[r]--;
                if (m_rem[r] == 0) m_busy[r] = 0;
            end
        end
        if (sbi.issue_valid && rdy && sbi.issue_wr && sbi.issue_rd != 5'd0) begin
            m_busy[sbi.issue_rd] = 1;
            m_long[sbi.issue_rd] = sbi.issue_long;
            m_rem[sbi.issue_rd]  = FIX_LAT;
        end
    endtask

    // Called at a falling edge with inputs already applied: compare all
    // outputs to the model, advance one clock, return at the next falling edge.
    task automatic tick(output logic rdy);
        bit          exp_rdy;
        logic [31:0] exp_mask;
        int          pend;
        #1;
        exp_rdy  = model_ready();
        exp_mask = '0;
        pend     = 0;
        for (int r = 0; r < NREGS; r++) begin
            exp_mask[r] = m_busy[r];
            pend += int'(m_busy[r]);
        end
        check("issue_ready", {31'd0, sbi.issue_ready}, {31'd0, exp_rdy});
        check("busy_mask", sbi.busy_mask, exp_mask);
        check("pending_cnt", {26'd0, sbi.pending_cnt}, 32'(pend));
        check("stall_cnt", {16'd0, sbi.stall_cnt}, 32'(m_stall));
        check("err_spurious_wb", {31'd0, sbi.err_spurious_wb}, {31'd0, m_err});
        rdy = sbi.issue_ready;
        @(posedge clk);
        model_update(exp_rdy);
        @(negedge clk);
    endtask

    task automatic idle();
        sbi.issue_valid   = 0;
        sbi.issue_rs1     = 0;
        sbi.issue_rs2     = 0;
        sbi.issue_use_rs1 = 0;
        sbi.issue_use_rs2 = 0;
        sbi.issue_rd      = 0;
        sbi.issue_wr      = 0;
        sbi.issue_long    = 0;
        sbi.flush         = 0;
        sbi.wb_valid      = 0;
        sbi.wb_rd         = 0;
    endtask

    task automatic issue(input logic [4:0] rs1, input bit u1,
                         input logic [4:0] rs2, input bit u2,
                         input logic [4:0] rd, input bit wr, input bit lng);
        sbi.issue_valid   = 1;
        sbi.issue_rs1     = rs1;
        sbi.issue_use_rs1 = u1;
        sbi.issue_rs2     = rs2;
        sbi.issue_use_rs2 = u2;
        sbi.issue_rd      = rd;
        sbi.issue_wr      = wr;
        sbi.issue_long    = lng;
    endtask

    initial begin
        logic rdy;
        int   q[$];
        idle();
        rst_n = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        model_reset();

        // Reset values.
        check("rst busy_mask", sbi.busy_mask, 32'd0);
        check("rst pending_cnt", {26'd0, sbi.pending_cnt}, 32'd0);
        check("rst stall_cnt", {16'd0, sbi.stall_cnt}, 32'd0);
        check("rst err", {31'd0, sbi.err_spurious_wb}, 32'd0);
        #1 check("rst issue_ready", {31'd0, sbi.issue_ready}, 32'd1);

        // FIX write to x5, then a RS1=x5 reader.
        issue(0, 0, 0, 0, 5, 1, 0);
        tick(rdy);
        check("add accept", {31'd0, rdy}, 32'd1);
        check("add busy5 c1", {31'd0, sbi.busy_mask[5]}, 32'd1);
        issue(5, 1, 0, 0, 0, 0, 0);
        tick(rdy);
        check("raw5 ready c1", {31'd0, rdy}, 32'd0);
        check("add busy5 c2", {31'd0, sbi.busy_mask[5]}, 32'd1);
        tick(rdy);
`ifdef SCOREBOARD_WB_BYPASS_EN
        check("raw5 ready c2", {31'd0, rdy}, 32'd1);
        check("raw5 stall_cnt", {16'd0, sbi.stall_cnt}, 32'd1);
`else
        check("raw5 ready c2", {31'd0, rdy}, 32'd0);
        check("add busy5 clear", {31'd0, sbi.busy_mask[5]}, 32'd0);
        tick(rdy);
        check("raw5 ready c3", {31'd0, rdy}, 32'd1);
        check("raw5 stall_cnt", {16'd0, sbi.stall_cnt}, 32'd2);
`endif
        idle();
        tick(rdy);

        // LOAD x7, reader on RS2 waits for writeback.
        issue(0, 0, 0, 0, 7, 1, 1);
        tick(rdy);
        issue(0, 0, 7, 1, 0, 0, 0);
        repeat (3) begin
            tick(rdy);
            check("raw7 wait", {31'd0, rdy}, 32'd0);
        end
        sbi.wb_valid = 1;
        sbi.wb_rd    = 7;
        tick(rdy);
`ifdef SCOREBOARD_WB_BYPASS_EN
        check("raw7 wb cycle", {31'd0, rdy}, 32'd1);
`else
        check("raw7 wb cycle", {31'd0, rdy}, 32'd0);
`endif
        sbi.wb_valid = 0;
        tick(rdy);
        check("raw7 after wb", {31'd0, rdy}, 32'd1);
        check("load7 retired", {31'd0, sbi.busy_mask[7]}, 32'd0);
        idle();
        tick(rdy);

        // LOAD x7, then ADDI x7 (WAW) released by writeback.
        issue(0, 0, 0, 0, 7, 1, 1);
        tick(rdy);
        issue(1, 1, 0, 0, 7, 1, 0);
        repeat (2) begin
            tick(rdy);
            check("waw7 wait", {31'd0, rdy}, 32'd0);
        end
        sbi.wb_valid = 1;
        sbi.wb_rd    = 7;
        tick(rdy);
        sbi.wb_valid = 0;
`ifdef SCOREBOARD_WB_BYPASS_EN
        check("waw7 wb cycle", {31'd0, rdy}, 32'd1);
`else
        check("waw7 wb cycle", {31'd0, rdy}, 32'd0);
        tick(rdy);
        check("waw7 accept", {31'd0, rdy}, 32'd1);
`endif
        check("waw7 now fix busy", {31'd0, sbi.busy_mask[7]}, 32'd1);
        check("waw7 no err", {31'd0, sbi.err_spurious_wb}, 32'd0);
        idle();
        repeat (4) tick(rdy);

        // x0 never busy and never a hazard.
        issue(0, 1, 0, 1, 0, 1, 0);
        tick(rdy);
        check("x0 ready", {31'd0, rdy}, 32'd1);
        check("x0 mask", sbi.busy_mask, 32'd0);
        idle();

        // Spurious writeback, sticky until reset.
        sbi.wb_valid = 1;
        sbi.wb_rd    = 9;
        tick(rdy);
        sbi.wb_valid = 0;
        check("spurious err", {31'd0, sbi.err_spurious_wb}, 32'd1);
        tick(rdy);
        check("spurious sticky", {31'd0, sbi.err_spurious_wb}, 32'd1);
        issue(0, 0, 0, 0, 4, 1, 1);
        tick(rdy);
        idle();
        rst_n = 0;
        tick(rdy);
        rst_n = 1;
        check("rst2 busy_mask", sbi.busy_mask, 32'd0);
        check("rst2 pending", {26'd0, sbi.pending_cnt}, 32'd0);
        check("rst2 stall", {16'd0, sbi.stall_cnt}, 32'd0);
        check("rst2 err", {31'd0, sbi.err_spurious_wb}, 32'd0);
        // The discarded LOAD x4 now writes back: spurious.
        sbi.wb_valid = 1;
        sbi.wb_rd    = 4;
        tick(rdy);
        sbi.wb_valid = 0;
        check("discarded wb err", {31'd0, sbi.err_spurious_wb}, 32'd1);
        rst_n = 0;
        tick(rdy);
        rst_n = 1;

        // Flush blocks issue and counts as a stall.
        issue(0, 0, 0, 0, 3, 1, 0);
        sbi.flush = 1;
        tick(rdy);
        check("flush ready", {31'd0, rdy}, 32'd0);
        check("flush no set", sbi.busy_mask, 32'd0);
        check("flush stall", {16'd0, sbi.stall_cnt}, 32'd1);
        idle();
        tick(rdy);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            idle();
            sbi.issue_valid   = ($urandom % 4) != 0;
            sbi.issue_rs1     = 5'($urandom % 8);
            sbi.issue_rs2     = 5'($urandom % 8);
            sbi.issue_use_rs1 = 1'($urandom % 2);
            sbi.issue_use_rs2 = 1'($urandom % 2);
            sbi.issue_rd      = 5'($urandom % 8);
            sbi.issue_wr      = ($urandom % 10) < 7;
            sbi.issue_long    = ($urandom % 10) < 3;
            sbi.flush         = ($urandom % 16) == 0;
            q.delete();
            for (int r = 1; r < NREGS; r++)
                if (m_busy[r] && m_long[r]) q.push_back(r);
            if (q.size() > 0 && ($urandom % 3) == 0) begin
                sbi.wb_valid = 1;
                sbi.wb_rd    = 5'(q[$urandom % q.size()]);
            end else if (($urandom % 64) == 0) begin
                sbi.wb_valid = 1;
                sbi.wb_rd    = 5'($urandom % 32);
            end
            rst_n = ($urandom % 300) != 0;
            tick(rdy);
        end
        rst_n = 1;

        // Hold a stall long enough to saturate the counter.
        idle();
        sbi.issue_valid = 1;
        sbi.flush       = 1;
        repeat (STALL_MAX + 6) tick(rdy);
        check("stall saturated", {16'd0, sbi.stall_cnt}, 32'h0000FFFF);
        idle();
        tick(rdy);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
